// File: rtl/mips_isa_pkg.sv
// Shared MIPS P5-subset ISA definitions: instruction kind codes, opcode and
// func constants, and instruction field bit positions. The pipeline classifier
// imports the same package so encoder and classifier cannot drift apart.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    KindNop = 4'd0,
    KindAdd = 4'd1,
    KindSub = 4'd2,
    KindJr  = 4'd3,
    KindOri = 4'd4,
    KindLw  = 4'd5,
    KindSw  = 4'd6,
    KindBeq = 4'd7,
    KindLui = 4'd8,
    KindJal = 4'd9
  } kind_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FuncAdd = 6'b100000;
  localparam logic [5:0] FuncSub = 6'b100010;
  localparam logic [5:0] FuncJr  = 6'b001000;

  localparam int unsigned OpHi   = 31;
  localparam int unsigned OpLo   = 26;
  localparam int unsigned RsHi   = 25;
  localparam int unsigned RsLo   = 21;
  localparam int unsigned RtHi   = 20;
  localparam int unsigned RtLo   = 16;
  localparam int unsigned RdHi   = 15;
  localparam int unsigned RdLo   = 11;
  localparam int unsigned FuncHi = 5;
  localparam int unsigned FuncLo = 0;
  localparam int unsigned ImmHi  = 15;
  localparam int unsigned ImmLo  = 0;
  localparam int unsigned TargHi = 25;
  localparam int unsigned TargLo = 0;

  // Codes above KindJal are reserved and never produce a word.
  function automatic logic is_legal_kind(logic [3:0] kind);
    return kind <= KindJal;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/issue bus of the instruction encoder.
//   in_*  : request channel (valid/ready), kind code plus operand fields
//   out_* : issue channel (valid/ready), encoded word and its byte address
// modport master : request producer / issue consumer (loader or bench)
// modport slave  : the encoder itself
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm16;
  logic [25:0] in_addr26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm16, in_addr26, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm16, in_addr26, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full)
//   pop, rdata   : read request (ignored when empty), head data
//   full, empty  : occupancy flags
// Pointers are log2(Depth) bits and wrap naturally; a separate count one bit
// wider distinguishes full from empty.
module instr_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Assembles MIPS P5-subset instruction words from a kind code and operand
// fields, buffers them in a FIFO and issues them with incrementing addresses.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : request channel in, issue channel out (instr_encoder_if)
//   err          : sticky, an illegal kind was accepted
//   err_cnt      : illegal requests accepted, saturating at 255
//   issued_cnt   : words issued, wraps modulo 2^16
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset_n,
  instr_encoder_if.slave  bus,
  output logic            err,
  output logic [7:0]      err_cnt,
  output logic [15:0]     issued_cnt
);

  logic        ready_q;
  logic        full, empty;
  logic        accept, legal, push, bad, pop;
  logic [31:0] enc_word, head_word;
  logic [31:0] addr_q, addr_d;
  logic [15:0] issued_q, issued_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Unused fields of each kind stay at the zero default.
  always_comb begin
    enc_word = '0;
    case (bus.in_kind)
      KindAdd, KindSub: begin
        enc_word[OpHi:OpLo]     = OpRtype;
        enc_word[RsHi:RsLo]     = bus.in_rs;
        enc_word[RtHi:RtLo]     = bus.in_rt;
        enc_word[RdHi:RdLo]     = bus.in_rd;
        enc_word[FuncHi:FuncLo] = (bus.in_kind == KindAdd) ? FuncAdd : FuncSub;
      end
      KindJr: begin
        enc_word[OpHi:OpLo]     = OpRtype;
        enc_word[RsHi:RsLo]     = bus.in_rs;
        enc_word[FuncHi:FuncLo] = FuncJr;
      end
      KindOri, KindLw, KindSw, KindBeq: begin
        case (bus.in_kind)
          KindOri: enc_word[OpHi:OpLo] = OpOri;
          KindLw:  enc_word[OpHi:OpLo] = OpLw;
          KindSw:  enc_word[OpHi:OpLo] = OpSw;
          default: enc_word[OpHi:OpLo] = OpBeq;
        endcase
        enc_word[RsHi:RsLo]   = bus.in_rs;
        enc_word[RtHi:RtLo]   = bus.in_rt;
        enc_word[ImmHi:ImmLo] = bus.in_imm16;
      end
      KindLui: begin
        enc_word[OpHi:OpLo]   = OpLui;
        enc_word[RtHi:RtLo]   = bus.in_rt;
        enc_word[ImmHi:ImmLo] = bus.in_imm16;
      end
      KindJal: begin
        enc_word[OpHi:OpLo]     = OpJal;
        enc_word[TargHi:TargLo] = bus.in_addr26;
      end
      default: enc_word = '0;
    endcase
  end

  // in_ready depends only on occupancy, never on out_ready; a full FIFO
  // refuses a request even when a pop happens on the same edge.
  assign bus.in_ready  = ready_q & ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = head_word;
  assign bus.out_addr  = addr_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign legal  = is_legal_kind(bus.in_kind);
  assign push   = accept & legal;
  assign bad    = accept & ~legal;
  assign pop    = bus.out_valid & bus.out_ready;

  instr_fifo #(
    .Depth (DEPTH),
    .Width (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (enc_word),
    .pop     (pop),
    .rdata   (head_word),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    addr_d    = addr_q;
    issued_d  = issued_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (pop) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + 16'd1;
    end
    if (bad) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // ready_q holds in_ready low throughout reset and for no longer than one
  // edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      addr_q    <= BASE_ADDR;
      issued_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      ready_q   <= 1'b1;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign issued_cnt = issued_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Base  = 32'h0000_3000;

  logic        clk;
  logic        reset_n;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] issued_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] got_w[$];
  logic [31:0] got_a[$];
  int          got_c[$];

  instr_encoder_if bus ();

  instr_encoder #(
    .DEPTH     (Depth),
    .BASE_ADDR (Base)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .err        (err),
    .err_cnt    (err_cnt),
    .issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference encoding straight from the opcode/field table, via arithmetic.
  function automatic logic [31:0] ref_encode(longint kind, longint rs, longint rt, longint rd,
                                             longint imm, longint a26);
    case (kind)
      0:       return 32'h0;
      1:       return 32'((rs << 21) + (rt << 16) + (rd << 11) + 32);
      2:       return 32'((rs << 21) + (rt << 16) + (rd << 11) + 34);
      3:       return 32'((rs << 21) + 8);
      4:       return 32'((13 << 26) + (rs << 21) + (rt << 16) + imm);
      5:       return 32'((35 << 26) + (rs << 21) + (rt << 16) + imm);
      6:       return 32'((43 << 26) + (rs << 21) + (rt << 16) + imm);
      7:       return 32'((4 << 26) + (rs << 21) + (rt << 16) + imm);
      8:       return 32'((15 << 26) + (rt << 16) + imm);
      9:       return 32'((3 << 26) + a26);
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_kind   = 4'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_imm16  = 16'd0;
    bus.in_addr26 = 26'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    got_w.delete();
    got_a.delete();
    got_c.delete();
  endtask

  // Holds a request until accepted (bounded); returns on the negedge after the accept edge.
  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] a26,
                      output bit ok);
    bus.in_kind   = kind;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_imm16  = imm;
    bus.in_addr26 = a26;
    bus.in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Records issued words, sampling at negedges; stops after n words or budget cycles.
  task automatic collect(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.out_valid && bus.out_ready) begin
        got_w.push_back(bus.out_instr);
        got_a.push_back(bus.out_addr);
        got_c.push_back(cyc);
      end
      if (got_w.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_addr !== Base) begin errors++; $display("FAIL rst_out_addr got=%h exp=%h", bus.out_addr, Base); end
    checks++; if ({err, err_cnt, issued_cnt} !== 25'd0) begin
      errors++; $display("FAIL rst_counters got err=%b err_cnt=%0d issued=%0d exp all 0", err, err_cnt, issued_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept got=timeout exp=accepted"); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0022_1820) begin errors++; $display("FAIL add_instr got=%h exp=00221820", bus.out_instr); end
    checks++; if (bus.out_addr !== 32'h3000) begin errors++; $display("FAIL add_addr got=%h exp=3000", bus.out_addr); end
    @(negedge clk);
    checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL add_issued got=%0d exp=1", issued_cnt); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_addr !== 32'h3004) begin errors++; $display("FAIL add_next_addr got=%h exp=3004", bus.out_addr); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    logic [31:0] exp_w [3];
    exp_w = '{32'h3401_1234, 32'h8C43_0004, 32'h0C00_0C03};
    do_reset();
    bus.out_ready = 1'b1;
    fork
      begin
        send(4'd4, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, ok1);
        send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0004, 26'h0, ok2);
        send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03, ok3);
      end
      collect(3, 20);
    join
    checks++; if (got_w.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got_w.size()); end
    for (int i = 0; i < 3 && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i] || got_a[i] !== Base + 32'(4 * i)) begin
        errors++;
        $display("FAIL b2b_word%0d got=%h@%h exp=%h@%h", i, got_w[i], got_a[i], exp_w[i], Base + 32'(4 * i));
      end
    end
    if (got_c.size() == 3) begin
      checks++; if (got_c[2] - got_c[0] != 2) begin
        errors++; $display("FAIL b2b_throughput got=%0d cycles exp=2", got_c[2] - got_c[0]);
      end
    end
  endtask

  task automatic test_masking();
    bit ok;
    logic [31:0] exp_w [4];
    exp_w = '{32'h03E0_0008, 32'h3C01_ABCD, 32'h0085_3022, 32'h1022_FFFF};
    do_reset();
    bus.out_ready = 1'b1;
    fork
      begin
        send(4'd3, 5'd31, 5'd7, 5'd9, 16'hBEEF, 26'h3FF_FFFF, ok);
        send(4'd8, 5'd5, 5'd1, 5'd17, 16'hABCD, 26'h155_5555, ok);
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h3FF_FFFF, ok);
        send(4'd7, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AA_AAAA, ok);
      end
      collect(4, 20);
    join
    checks++; if (got_w.size() != 4) begin errors++; $display("FAIL mask_count got=%0d exp=4", got_w.size()); end
    for (int i = 0; i < 4 && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL mask_word%0d got=%h exp=%h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'd4, 5'd0, 5'd1, 5'd0, 16'h1000 + 16'(i), 26'h0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_accept%0d got=timeout exp=accepted", i); end
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready); end
    bus.in_kind = 4'd4; bus.in_rt = 5'd1; bus.in_imm16 = 16'h1004; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h3401_1000 || bus.out_addr !== Base) begin
        errors++;
        $display("FAIL bp_stall%0d got ready=%b %h@%h exp ready=0 34011000@%h", i, bus.in_ready,
                 bus.out_instr, bus.out_addr, Base);
      end
    end
    bus.out_ready = 1'b1;
    fork
      send(4'd4, 5'd0, 5'd1, 5'd0, 16'h1004, 26'h0, ok);
      collect(5, 40);
    join
    // First edge with out_ready high pops while the FIFO is still full.
    if (got_c.size() >= 1) begin
      checks++; if (got_w.size() != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", got_w.size()); end
    end
    for (int i = 0; i < 5 && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== 32'h3401_1000 + 32'(i) || got_a[i] !== Base + 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_word%0d got=%h@%h exp=%h@%h", i, got_w[i], got_a[i], 32'h3401_1000 + 32'(i),
                 Base + 32'(4 * i));
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (issued_cnt !== 16'd5 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_final got issued=%0d valid=%b exp issued=5 valid=0", issued_cnt, bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    fork
      begin
        send(4'd0, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h1, ok);
        send(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, ok);
        send(4'd0, 5'd7, 5'd7, 5'd7, 16'hAAAA, 26'h2, ok);
      end
      collect(2, 20);
    join
    repeat (3) @(negedge clk);
    checks++; if (got_w.size() != 2) begin errors++; $display("FAIL ill_count got=%0d exp=2", got_w.size()); end
    for (int i = 0; i < 2 && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== 32'h0 || got_a[i] !== Base + 32'(4 * i)) begin
        errors++; $display("FAIL ill_nop%0d got=%h@%h exp=0@%h", i, got_w[i], got_a[i], Base + 32'(4 * i));
      end
    end
    checks++; if (err !== 1'b1 || err_cnt !== 8'd1 || issued_cnt !== 16'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ill_status got err=%b cnt=%0d issued=%0d valid=%b exp 1/1/2/0", err, err_cnt,
               issued_cnt, bus.out_valid);
    end
    bus.in_kind = 4'd13;
    bus.in_valid = 1'b1;
    repeat (253) @(negedge clk);
    checks++; if (err_cnt !== 8'd254) begin errors++; $display("FAIL ill_cnt254 got=%0d exp=254", err_cnt); end
    repeat (47) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL ill_sat got=%0d exp=255", err_cnt); end
    checks++; if (bus.out_valid !== 1'b0 || issued_cnt !== 16'd2) begin
      errors++; $display("FAIL ill_no_push got valid=%b issued=%0d exp 0/2", bus.out_valid, issued_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, ok);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got=%b exp=1", bus.out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_async got valid=%b ready=%b exp 0/0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_addr !== 32'h3000 || issued_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_after got %h issued=%0d exp 3000 issued=0", bus.out_addr, issued_cnt);
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || issued_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_no_issue got valid=%b issued=%0d exp 0/0", bus.out_valid, issued_cnt);
    end
    got_w.delete(); got_a.delete(); got_c.delete();
    fork
      send(4'd6, 5'd9, 5'd10, 5'd0, 16'h0040, 26'h0, ok);
      collect(1, 10);
    join
    checks++; if (got_w.size() != 1 || got_w[0] !== 32'hAD2A_0040 || got_a[0] !== 32'h3000) begin
      errors++; $display("FAIL mid_fresh got n=%0d exp one AD2A0040@3000", got_w.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_addr;
    logic [15:0] exp_issued;
    int          exp_ecnt;
    bit          exp_err;
    bit          acc, pop;
    logic [3:0]  kind;
    do_reset();
    exp_addr = Base; exp_issued = 0; exp_ecnt = 0; exp_err = 0;
    for (int c = 0; c < 600; c++) begin
      checks++; if (bus.in_ready !== (q.size() < Depth) || bus.out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rnd_flags c=%0d got ready=%b valid=%b exp occ=%0d", c, bus.in_ready,
                 bus.out_valid, q.size());
      end
      if (q.size() > 0) begin
        checks++; if (bus.out_instr !== q[0] || bus.out_addr !== exp_addr) begin
          errors++;
          $display("FAIL rnd_head c=%0d got=%h@%h exp=%h@%h", c, bus.out_instr, bus.out_addr, q[0], exp_addr);
        end
      end
      checks++; if (err !== exp_err || err_cnt !== 8'(exp_ecnt) || issued_cnt !== exp_issued) begin
        errors++;
        $display("FAIL rnd_status c=%0d got %b/%0d/%0d exp %b/%0d/%0d", c, err, err_cnt, issued_cnt,
                 exp_err, exp_ecnt, exp_issued);
      end
      kind = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      bus.in_kind   = kind;
      bus.in_rs     = 5'($urandom);
      bus.in_rt     = 5'($urandom);
      bus.in_rd     = 5'($urandom);
      bus.in_imm16  = 16'($urandom);
      bus.in_addr26 = 26'($urandom);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc = bus.in_valid && (q.size() < Depth);
      pop = bus.out_ready && (q.size() > 0);
      if (pop) begin
        void'(q.pop_front());
        exp_addr += 32'd4;
        exp_issued += 16'd1;
      end
      if (acc) begin
        if (kind <= 4'd9) begin
          q.push_back(ref_encode(kind, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm16, bus.in_addr26));
        end else begin
          exp_err = 1'b1;
          if (exp_ecnt < 255) exp_ecnt++;
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_add();
    test_back_to_back();
    test_masking();
    test_backpressure();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
